// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier. It takes operands into a register, then unpacks, multiplies, and normalizes/rounds.
// A result refused by the consumer freezes every stage; bubbles are not collapsed.
module fmul_pipe #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  // input capture
  logic v0_q, v0_d;
  logic [W-1:0] a0_q, a0_d, b0_q, b0_d;
  // stage 1: unpacked operands
  logic v1_q, v1_d, sign1_q, sign1_d, spec1_q, spec1_d;
  logic [EXP_W-1:0] ea1_q, ea1_d, eb1_q, eb1_d;
  logic [SW-1:0] siga1_q, siga1_d, sigb1_q, sigb1_d;
  logic [W-1:0] spec_res1_q, spec_res1_d;
  logic [3:0] spec_flags1_q, spec_flags1_d;
  // stage 2: raw product
  logic v2_q, v2_d, sign2_q, sign2_d, spec2_q, spec2_d;
  logic [PW-1:0] prod2_q, prod2_d;
  logic signed [EW-1:0] exp2_q, exp2_d;
  logic [W-1:0] spec_res2_q, spec_res2_d;
  logic [3:0] spec_flags2_q, spec_flags2_d;
  // stage 3: output register
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic [3:0] out_flags_q, out_flags_d;

  logic stall;
  logic [EXP_W-1:0] ea_c, eb_c;
  logic [MAN_W-1:0] fa_c, fb_c;
  logic za_c, zb_c, ia_c, ib_c, na_c, nb_c, sna_c, snb_c, sign_c, spec_c;
  logic [W-1:0] spec_res_c;
  logic [3:0] spec_flags_c;
  logic msb_c, g_c, r_c, st_c, round_up_c, carry_c;
  logic [MAN_W-1:0] frac_c, frac_r_c;
  logic signed [EW-1:0] e_n_c, e_r_c;
  logic [W-1:0] res_c;
  logic [3:0] flags_c;

  assign stall      = out_valid_q & ~out_ready;
  assign in_ready   = ~stall;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // Stage 1: classify operands (subnormals read as zero) and resolve special results
  always_comb begin
    ea_c   = a0_q[W-2:MAN_W];
    eb_c   = b0_q[W-2:MAN_W];
    fa_c   = a0_q[MAN_W-1:0];
    fb_c   = b0_q[MAN_W-1:0];
    sign_c = a0_q[W-1] ^ b0_q[W-1];
    za_c   = (ea_c == '0);
    zb_c   = (eb_c == '0);
    ia_c   = (ea_c == '1) && (fa_c == '0);
    ib_c   = (eb_c == '1) && (fb_c == '0);
    na_c   = (ea_c == '1) && (fa_c != '0);
    nb_c   = (eb_c == '1) && (fb_c != '0);
    sna_c  = na_c & ~fa_c[MAN_W-1];
    snb_c  = nb_c & ~fb_c[MAN_W-1];
    spec_c       = 1'b1;
    spec_res_c   = '0;
    spec_flags_c = 4'b0000;
    if (na_c || nb_c) begin
      spec_res_c   = QNAN;
      spec_flags_c = {sna_c | snb_c, 3'b000};
    end else if ((ia_c && zb_c) || (za_c && ib_c)) begin
      spec_res_c   = QNAN;
      spec_flags_c = 4'b1000;
    end else if (ia_c || ib_c) begin
      spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (za_c || zb_c) begin
      spec_res_c = {sign_c, {(W - 1){1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  // Stage 3: normalize, flush tiny results, round to nearest even, saturate to infinity
  always_comb begin
    msb_c = prod2_q[PW-1];
    if (msb_c) begin
      frac_c = prod2_q[PW-2:MAN_W+1];
      g_c    = prod2_q[MAN_W];
      r_c    = prod2_q[MAN_W-1];
      st_c   = |prod2_q[MAN_W-2:0];
    end else begin
      frac_c = prod2_q[PW-3:MAN_W];
      g_c    = prod2_q[MAN_W-1];
      r_c    = prod2_q[MAN_W-2];
      st_c   = |prod2_q[MAN_W-3:0];
    end
    e_n_c      = exp2_q + $signed(EW'(msb_c));
    round_up_c = g_c & (r_c | st_c | frac_c[0]);
    // a carry out of the fraction means the significand became 2.0, so fraction is zero
    {carry_c, frac_r_c} = {1'b0, frac_c} + SW'(round_up_c);
    e_r_c = e_n_c + $signed(EW'(carry_c));
    res_c   = '0;
    flags_c = 4'b0000;
    if (spec2_q) begin
      res_c   = spec_res2_q;
      flags_c = spec_flags2_q;
    end else if (e_n_c < E_ONE) begin
      res_c   = {sign2_q, {(W - 1){1'b0}}};
      flags_c = {3'b001, |prod2_q};
    end else if (e_r_c >= EMAX) begin
      res_c   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end else begin
      res_c   = {sign2_q, e_r_c[EXP_W-1:0], frac_r_c};
      flags_c = {3'b000, g_c | r_c | st_c};
    end
  end

  // Next state: hold on stall, clear valids and outputs on reset, otherwise advance
  always_comb begin
    v0_d = v0_q; a0_d = a0_q; b0_d = b0_q;
    v1_d = v1_q; sign1_d = sign1_q; spec1_d = spec1_q; ea1_d = ea1_q; eb1_d = eb1_q;
    siga1_d = siga1_q; sigb1_d = sigb1_q; spec_res1_d = spec_res1_q; spec_flags1_d = spec_flags1_q;
    v2_d = v2_q; sign2_d = sign2_q; spec2_d = spec2_q; prod2_d = prod2_q; exp2_d = exp2_q;
    spec_res2_d = spec_res2_q; spec_flags2_d = spec_flags2_q;
    out_valid_d = out_valid_q; out_result_d = out_result_q; out_flags_d = out_flags_q;
    if (rst) begin
      v0_d = 1'b0; v1_d = 1'b0; v2_d = 1'b0;
      out_valid_d = 1'b0; out_result_d = '0; out_flags_d = 4'b0000;
    end else if (!stall) begin
      v0_d = in_valid; a0_d = in_a; b0_d = in_b;
      v1_d = v0_q; sign1_d = sign_c; spec1_d = spec_c; ea1_d = ea_c; eb1_d = eb_c;
      siga1_d = {1'b1, fa_c}; sigb1_d = {1'b1, fb_c};
      spec_res1_d = spec_res_c; spec_flags1_d = spec_flags_c;
      v2_d = v1_q; sign2_d = sign1_q; spec2_d = spec1_q;
      prod2_d = PW'(siga1_q) * PW'(sigb1_q);
      exp2_d = $signed(EW'(ea1_q)) + $signed(EW'(eb1_q)) - BIAS;
      spec_res2_d = spec_res1_q; spec_flags2_d = spec_flags1_q;
      out_valid_d = v2_q; out_result_d = res_c; out_flags_d = flags_c;
    end
  end

  always_ff @(posedge clk) begin
    v0_q <= v0_d; a0_q <= a0_d; b0_q <= b0_d;
    v1_q <= v1_d; sign1_q <= sign1_d; spec1_q <= spec1_d; ea1_q <= ea1_d; eb1_q <= eb1_d;
    siga1_q <= siga1_d; sigb1_q <= sigb1_d; spec_res1_q <= spec_res1_d; spec_flags1_q <= spec_flags1_d;
    v2_q <= v2_d; sign2_q <= sign2_d; spec2_q <= spec2_d; prod2_q <= prod2_d; exp2_q <= exp2_d;
    spec_res2_q <= spec_res2_d; spec_flags2_q <= spec_flags2_d;
    out_valid_q <= out_valid_d; out_result_q <= out_result_d; out_flags_q <= out_flags_d;
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: binary32 and 5/10-bit instances checked against an exact-arithmetic model.
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rst;
  logic v32, ir32, or32, ov32;
  logic [31:0] a32, b32, res32;
  logic [3:0] fl32;
  logic v16, ir16, or16, ov16;
  logic [15:0] a16, b16, res16;
  logic [3:0] fl16;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;
  exp_t sb[$];
  logic [31:0] opa[$], opb[$];

  fmul_pipe u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .out_valid(ov32), .out_ready(or32), .out_result(res32), .out_flags(fl32)
  );

  fmul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(or16), .out_result(res16), .out_flags(fl16)
  );

  always #5 clk = ~clk;

  // Exact product of the significands, rounded by remainder comparison
  function automatic exp_t ref_mul(int ew, int mw, logic [31:0] a, logic [31:0] b);
    longint unsigned fm, emax, ea, eb, fa, fb, p, q, rem, half, qnan, sgn;
    int e, sh, bias;
    bit na, nb, sna, snb, ia, ib, za, zb;
    exp_t o;
    fm   = (64'd1 << mw) - 1;
    emax = (64'd1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ea = (64'(a) >> mw) & emax;
    eb = (64'(b) >> mw) & emax;
    fa = 64'(a) & fm;
    fb = 64'(b) & fm;
    sgn  = (a[ew+mw] ^ b[ew+mw]) ? (64'd1 << (ew + mw)) : 64'd0;
    qnan = (emax << mw) | (64'd1 << (mw - 1));
    na = (ea == emax) && (fa != 0);
    nb = (eb == emax) && (fb != 0);
    sna = na && (((fa >> (mw - 1)) & 1) == 0);
    snb = nb && (((fb >> (mw - 1)) & 1) == 0);
    ia = (ea == emax) && (fa == 0);
    ib = (eb == emax) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    o.f = 4'b0000;
    if (na || nb) begin
      o.r = 32'(qnan); o.f = {sna || snb, 3'b000};
    end else if ((ia && zb) || (za && ib)) begin
      o.r = 32'(qnan); o.f = 4'b1000;
    end else if (ia || ib) begin
      o.r = 32'(sgn | (emax << mw));
    end else if (za || zb) begin
      o.r = 32'(sgn);
    end else begin
      p = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
      e = int'(ea) + int'(eb) - bias;
      if (p >= (64'd1 << (2 * mw + 1))) begin
        sh = mw + 1; e++;
      end else begin
        sh = mw;
      end
      if (e < 1) begin
        o.r = 32'(sgn); o.f = 4'b0011;
      end else begin
        q = p >> sh;
        rem = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << (mw + 1))) begin
          q = q >> 1; e++;
        end
        if (e >= int'(emax)) begin
          o.r = 32'(sgn | (emax << mw)); o.f = 4'b0101;
        end else begin
          o.r = 32'(sgn | (longint'(e) << mw) | (q & fm));
          o.f = {3'b000, rem != 0};
        end
      end
    end
    return o;
  endfunction

  // Random operand biased toward zero/subnormal, inf/NaN and exact significands
  function automatic logic [31:0] rand_op(int ew, int mw);
    longint unsigned e, f, s;
    int sel;
    f = longint'($urandom) & ((64'd1 << mw) - 1);
    e = $urandom_range((1 << ew) - 1, 0);
    s = $urandom_range(1, 0);
    sel = $urandom_range(7, 0);
    if (sel == 0) e = 0;
    else if (sel == 1) e = (64'd1 << ew) - 1;
    else if (sel == 2) f = 0;
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ordy);
    @(negedge clk);
    v32 = v; a32 = a; b32 = b; or32 = ordy;
    #1;
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ordy);
    @(negedge clk);
    v16 = v; a16 = a; b16 = b; or16 = ordy;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    total++;
    if (ov32 !== 1'b0 || res32 !== 32'h0 || fl32 !== 4'h0 || ir32 !== 1'b1) begin
      bad++;
      $display("FAIL reset32: valid=%b result=%h flags=%b ready=%b want 0 0 0 1", ov32, res32, fl32, ir32);
    end
    total++;
    if (ov16 !== 1'b0 || res16 !== 16'h0 || fl16 !== 4'h0 || ir16 !== 1'b1) begin
      bad++;
      $display("FAIL reset16: valid=%b result=%h flags=%b ready=%b want 0 0 0 1", ov16, res16, fl16, ir16);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] wr;
    for (int k = 0; k < 8; k++) begin
      drive32(k < 2, (k == 0) ? 32'h40000000 : 32'hC0000000, 32'h40400000, 1'b1);
      total++;
      if (ov32 !== (k == 4 || k == 5)) begin
        bad++;
        $display("FAIL b2b_valid cycle %0d: out_valid=%b want %b", k, ov32, (k == 4 || k == 5));
      end
      if (k == 4 || k == 5) begin
        wr = (k == 4) ? 32'h40C00000 : 32'hC0C00000;
        total++;
        if (res32 !== wr || fl32 !== 4'b0000) begin
          bad++;
          $display("FAIL b2b_result cycle %0d: got %h/%b want %h/0000", k, res32, fl32, wr);
        end
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] da[8] = '{32'h3F800001, 32'h3F800001, 32'h7F800000, 32'h7FFFFFFF,
                            32'h7F800001, 32'h80000000, 32'h7F7FFFFF, 32'h00800000};
    logic [31:0] db[8] = '{32'h3FC00000, 32'h3F800001, 32'h00000000, 32'h3F800000,
                            32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h3F000000};
    logic [31:0] dr[8] = '{32'h3FC00002, 32'h3F800002, 32'h7FC00000, 32'h7FC00000,
                            32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
    logic [3:0]  df[8] = '{4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0101, 4'b0011};
    int i = 0;
    int idx;
    exp_t e, g;
    sb.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      idx = (i < 8) ? i : 0;
      drive32(i < 8, da[idx], db[idx], 1'b1);
      if (v32 && ir32) begin
        e.r = dr[i]; e.f = df[i]; sb.push_back(e); i++;
      end
      if (ov32 && or32) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL directed: unexpected result %h", res32);
        end else begin
          g = sb.pop_front();
          if (res32 !== g.r || fl32 !== g.f) begin
            bad++; $display("FAIL directed: got %h/%b want %h/%b", res32, fl32, g.r, g.f);
          end
        end
      end
    end
    total++;
    if (i != 8 || sb.size() != 0) begin
      bad++; $display("FAIL directed_drain: issued=%0d pending=%0d want 8 0", i, sb.size());
    end
  endtask

  // Streams opa/opb through the 32-bit instance with the given out_ready pattern
  task automatic test_stream32(input string name, input int mode);
    int i = 0;
    int n;
    int delivered = 0;
    logic vv, rr;
    exp_t g;
    sb.delete();
    n = opa.size();
    for (int cyc = 0; cyc < n * 6 + 30; cyc++) begin
      if (mode == 0) begin
        vv = (i < n); rr = !(cyc >= 4 && cyc <= 7);
      end else begin
        vv = (i < n) && ($urandom_range(3, 0) != 0); rr = ($urandom_range(3, 0) != 0);
      end
      drive32(vv, (i < n) ? opa[i] : 32'h0, (i < n) ? opb[i] : 32'h0, rr);
      total++;
      if (ir32 !== !(ov32 && !or32)) begin
        bad++; $display("FAIL %s_ready cycle %0d: in_ready=%b out_valid=%b out_ready=%b", name, cyc, ir32, ov32, or32);
      end
      if (v32 && ir32) begin
        sb.push_back(ref_mul(8, 23, opa[i], opb[i])); i++;
      end
      if (ov32 && or32) begin
        total++;
        delivered++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL %s: unexpected result %h", name, res32);
        end else begin
          g = sb.pop_front();
          if (res32 !== g.r || fl32 !== g.f) begin
            bad++; $display("FAIL %s: got %h/%b want %h/%b", name, res32, fl32, g.r, g.f);
          end
        end
      end
      if (i == n && sb.size() == 0 && !ov32) break;
    end
    total++;
    if (delivered != n || sb.size() != 0) begin
      bad++; $display("FAIL %s_count: delivered=%0d pending=%0d want %0d 0", name, delivered, sb.size(), n);
    end
  endtask

  task automatic test_backpressure;
    opa.delete(); opb.delete();
    for (int k = 0; k < 5; k++) begin
      opa.push_back(rand_op(8, 23)); opb.push_back(rand_op(8, 23));
    end
    test_stream32("backpressure", 0);
  endtask

  task automatic test_random;
    opa.delete(); opb.delete();
    for (int k = 0; k < 300; k++) begin
      opa.push_back(rand_op(8, 23)); opb.push_back(rand_op(8, 23));
    end
    test_stream32("random32", 1);
  endtask

  task automatic test_half;
    int i = 0;
    int n = 102;
    int delivered = 0;
    logic [15:0] ha[$], hb[$];
    exp_t g, e;
    sb.delete();
    ha.push_back(16'h4000); hb.push_back(16'h4200);
    ha.push_back(16'h7BFF); hb.push_back(16'h7BFF);
    for (int k = 2; k < n; k++) begin
      ha.push_back(16'(rand_op(5, 10))); hb.push_back(16'(rand_op(5, 10)));
    end
    for (int cyc = 0; cyc < n * 6 + 30; cyc++) begin
      drive16(i < n, (i < n) ? ha[i] : 16'h0, (i < n) ? hb[i] : 16'h0, $urandom_range(3, 0) != 0);
      if (v16 && ir16) begin
        if (i == 0) begin
          e.r = 32'h4600; e.f = 4'b0000;
        end else if (i == 1) begin
          e.r = 32'h7C00; e.f = 4'b0101;
        end else begin
          e = ref_mul(5, 10, 32'(ha[i]), 32'(hb[i]));
        end
        sb.push_back(e); i++;
      end
      if (ov16 && or16) begin
        total++;
        delivered++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL half: unexpected result %h", res16);
        end else begin
          g = sb.pop_front();
          if (res16 !== g.r[15:0] || fl16 !== g.f) begin
            bad++; $display("FAIL half: got %h/%b want %h/%b", res16, fl16, g.r[15:0], g.f);
          end
        end
      end
      if (i == n && sb.size() == 0 && !ov16) break;
    end
    total++;
    if (delivered != n) begin
      bad++; $display("FAIL half_count: delivered=%0d want %0d", delivered, n);
    end
  endtask

  task automatic test_reset_midstream;
    for (int k = 0; k < 12; k++) begin
      drive32(k < 3 || k == 4, (k == 4) ? 32'h40000000 : rand_op(8, 23),
              (k == 4) ? 32'h40400000 : rand_op(8, 23), 1'b1);
      rst = (k == 2);
      if (k >= 3) begin
        total++;
        if (ov32 !== (k == 8)) begin
          bad++; $display("FAIL reset_mid_valid cycle %0d: out_valid=%b want %b", k, ov32, (k == 8));
        end
        if (k == 8) begin
          total++;
          if (res32 !== 32'h40C00000 || fl32 !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_result: got %h/%b want 40c00000/0000", res32, fl32);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    test_reset();
    test_back_to_back();
    test_directed();
    test_backpressure();
    test_random();
    test_half();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. Successor to the combinational single-precision fmul.
- Adds configurable exponent/mantissa width, a 3-stage pipeline with valid/ready handshake and backpressure, round-to-nearest-even, and exception flags.
- Sits between operand-issue logic and result writeback in the FP datapath. Default configuration is binary32.

Parameters:
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored fraction width (≥4).
- W, 1+EXP_W+MAN_W, total operand width (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  W  product.
- out_flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared, out_valid=0, out_result=0, out_flags=0. In-flight operations are discarded. No output appears for data accepted before reset.
- Transfer rules: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
- Stall: stall = out_valid & ~out_ready. On stall, the whole pipeline holds and in_ready=0. Otherwise in_ready=1, including while rst is asserted (data is then ignored).
- Bubbles are not collapsed; a stall freezes all stages.
- Latency: 3 cycles. Operands accepted at edge N give out_valid=1 after edge N+3 with no stall. Throughput is 1 per cycle.
- Stage 1: unpack sign/exponent/fraction; classify each operand as zero, subnormal, normal, inf, qNaN or sNaN. Subnormal inputs are treated as zero (DAZ). Result sign = sign_a ^ sign_b.
- Stage 2: (MAN_W+1)x(MAN_W+1) significand product, width 2*MAN_W+2. Exponent sum e = ea + eb − bias, computed in signed EXP_W+2 bits, with bias = 2^(EXP_W−1)−1.
- Stage 3 normalize: if product MSB is set, shift right 1 and e+1.
- Stage 3 underflow (tininess before rounding): if normalized biased e < 1, flush to signed zero; underflow=1; inexact=1 if the product was nonzero.
- Stage 3 rounding: round to nearest, ties to even, using guard, round and OR-sticky bits. A rounding carry out of the significand increments e.
- Stage 3 overflow: if e ≥ 2^EXP_W−1 after rounding, result is signed infinity with overflow=1 and inexact=1.
- inexact=1 whenever any discarded bit is nonzero.
- Special cases, highest priority first:
  - Any NaN input gives canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0. invalid=1 only if an input is sNaN (exponent all ones, fraction≠0, fraction MSB 0).
  - inf × zero gives canonical qNaN with invalid=1.
  - inf × finite-nonzero or inf × inf gives signed inf with all flags 0.
  - zero × finite gives signed zero with all flags 0; −0 × −0 = +0.
- Flags are per result and are valid only with out_valid; they are not sticky.

Test Plan:
- Default params, back-to-back: 0x40000000×0x40400000, then 0xC0000000×0x40400000, out_ready=1 → out_valid on cycles 3 and 4 with results 0x40C00000 and 0xC0C00000, flags 0.
- Tie rounding: 0x3F800001×0x3FC00000 → 0x3FC00002, flags 0001. Also 0x3F800001×0x3F800001 → 0x3F800002, flags 0001.
- Specials: 0x7F800000×0x00000000 → 0x7FC00000 flags 1000; 0x7FFFFFFF×0x3F800000 → 0x7FC00000 flags 0000; 0x7F800001×0x3F800000 → 0x7FC00000 flags 1000; 0x80000000×0x80000000 → 0x00000000 flags 0000.
- Range: 0x7F7FFFFF×0x7F7FFFFF → 0x7F800000 flags 0101. 0x00800000×0x3F000000 → 0x00000000 flags 0011.
- Backpressure: stream 5 operand pairs with out_ready low for cycles 4–7 → in_ready=0 exactly while out_valid&~out_ready. All 5 results delivered in order, none lost or duplicated. rst pulsed mid-stream → out_valid=0 next cycle and no stale results afterwards.
- EXP_W=5, MAN_W=10: 0x4000×0x4200 → 0x4600; 0x7BFF×0x7BFF → 0x7C00 flags 0101.
